// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone classic slave that feeds a small byte FIFO into an
// 8N1 serial transmitter with a programmable bit period of DIV+1 clocks.
// Registers: 0x0 DATA (push), 0x4 STATUS, 0x8 DIV, 0xC reserved (err_o).
module wb_uart_tx #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o,
    output logic        tx_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [2:0]       bit_cnt;
    logic [15:0]      baud_cnt;
    logic [7:0]       shift;
    logic [15:0]      div_q;
    logic [15:0]      div;
    logic             ovf;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             req;
    logic [1:0]       reg_sel;
    logic             wr_data;
    logic             wr_status;
    logic             wr_div;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             busy;
    logic [31:0]      rd_data;
    logic             unused_bits;

    // A new request is only recognised when no termination is in flight, so a
    // strobe held through the ack cycle is not counted twice.
    assign req       = cyc_i & stb_i & ~ack_o & ~err_o;
    assign reg_sel   = adr_i[3:2];
    assign wr_data   = req & we_i & (reg_sel == 2'd0) & sel_i[0];
    assign wr_status = req & we_i & (reg_sel == 2'd1) & sel_i[0];
    assign wr_div    = req & we_i & (reg_sel == 2'd2);

    // FULL is judged before the edge, so a push in the same cycle as a pop
    // from a full FIFO is still dropped.
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = wr_data & ~full;
    assign pop   = (state == IDLE) & ~empty;
    assign busy  = (state != IDLE);
    assign rty_o = 1'b0;

    assign unused_bits = ^{adr_i[31:4], adr_i[1:0], dat_i[31:16], dat_i[7:4], sel_i[3:2]};

    // Read mux reflecting register state in the request cycle.
    always_comb begin
        rd_data = 32'd0;
        case (reg_sel)
            2'd1:    rd_data = {28'd0, ovf, busy, full, empty};
            2'd2:    rd_data = {16'd0, div};
            default: rd_data = 32'd0;
        endcase
    end

    // Bus termination and registered read data, one cycle after the request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= 32'd0;
        end else begin
            ack_o <= req & (reg_sel != 2'd3);
            err_o <= req & (reg_sel == 2'd3);
            dat_o <= (req & ~we_i) ? rd_data : 32'd0;
        end
    end

    // Divider register and sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div <= DEFAULT_DIV;
            ovf <= 1'b0;
        end else begin
            if (wr_div && sel_i[0]) div[7:0]  <= dat_i[7:0];
            if (wr_div && sel_i[1]) div[15:8] <= dat_i[15:8];
            if (wr_data && full) begin
                ovf <= 1'b1;
            end else if (wr_status && dat_i[3]) begin
                ovf <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset because count guards every read.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= dat_i[7:0];
    end

    // FIFO pointers and occupancy, wrapping naturally at the power-of-two depth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Transmit FSM; tx_o is registered so the line never sees bus glitches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            baud_cnt <= 16'd0;
            shift    <= 8'd0;
            div_q    <= 16'd0;
            tx_o     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                    if (!empty) begin
                        shift    <= fifo_mem[rd_ptr];
                        div_q    <= div;
                        baud_cnt <= 16'd0;
                        bit_cnt  <= 3'd0;
                        tx_o     <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == div_q) begin
                        baud_cnt <= 16'd0;
                        tx_o     <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == div_q) begin
                        baud_cnt <= 16'd0;
                        if (bit_cnt == 3'd7) begin
                            tx_o  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= shift >> 1;
                            tx_o    <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_cnt == div_q) begin
                        baud_cnt <= 16'd0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
